uart_rx_deserializer: RTL and testbench
=======================================

// Module: uart_rx_deserializer
//
// PURPOSE
// Serial-to-parallel UART receiver; the downstream partner of the UART TX stage.
// Consumes the TX_OUT line, oversamples it with majority voting and rebuilds
// START/DATA/PARITY/STOP frames. Presents P_DATA with a one-cycle DATA_VALID
// strobe, or flags parity/stop errors. Closes the TX loopback in the UART bench.
//
// PARAMETERS
// DATA_WIDTH  8  payload bits per frame, LSB first
// OVERSAMPLE  8  clk cycles per serial bit; even, >= 4
//
// PORTS
// clk         in   1           system clock, rising edge
// reset       in   1           asynchronous, active-low reset
// RX_IN       in   1           serial line (idle high)
// PAR_EN      in   1           1 = frame carries a parity bit
// PAR_TYP     in   1           0 = even parity, 1 = odd parity
// P_DATA      out  DATA_WIDTH  last good payload
// DATA_VALID  out  1           1-cycle strobe: P_DATA updated, frame good
// PAR_ERR     out  1           1-cycle strobe: parity mismatch
// STP_ERR     out  1           1-cycle strobe: stop bit sampled 0
// Busy        out  1           high while a frame is being received
//
// BEHAVIOUR
// - Reset (reset=0, async): state=IDLE, counters=0, armed=1.
//   Outputs: P_DATA=0, DATA_VALID=0, PAR_ERR=0, STP_ERR=0, Busy=0.
//   Synchronizer flops are preset to 1.
// - RX_IN passes through a 2-flop synchronizer (rx_s); rx_s lags RX_IN by 2 cycles.
// - FSM states: IDLE, START, DATA, PARITY, STOP.
//   edge_cnt counts 0..OVERSAMPLE-1 per bit; bit_cnt counts 0..DATA_WIDTH-1.
// - Bit sampling: samples at edge_cnt = OS/2-1, OS/2, OS/2+1; bit = majority of 3.
//   Each bit is resolved at edge_cnt==OS-1; transitions happen on that edge only.
// - IDLE -> START when armed && rx_s==0; edge_cnt cleared; PAR_EN/PAR_TYP latched.
//   Later PAR_EN/PAR_TYP changes do not affect the frame in flight.
// - START: resolved bit 1 -> glitch, back to IDLE, no strobes.
//   Resolved bit 0 -> DATA.
// - DATA: shift into rx_shift LSB first; after bit DATA_WIDTH-1 go to
//   PARITY if PAR_EN, else STOP.
// - PARITY: expected = ^rx_shift ^ PAR_TYP; a mismatch sets a pending par_err.
// - STOP: resolved 1 and no pending par_err -> P_DATA<=rx_shift, DATA_VALID=1.
//   Resolved 1 with pending par_err -> PAR_ERR=1; P_DATA holds its old value.
//   Resolved 0 -> STP_ERR=1 only (overrides PAR_ERR); P_DATA holds; armed<=0.
//   In every case the FSM returns to IDLE.
// - armed=0 blocks start detection until rx_s==1 is seen for one cycle.
//   This prevents a break or stuck-low line from retriggering frames.
// - Strobes are registered; each is high for exactly the one cycle after the STOP resolve edge.
//   At most one strobe fires per frame.
// - Busy: 1 from the IDLE->START edge until the STOP resolve edge; 0 in IDLE.
// - Latency: first strobe at N*OS+3 cycles after the first clk edge that samples RX_IN=0.
//   N = 10 + PAR_EN for DATA_WIDTH=8.
// - Back-to-back frames: a start bit that directly follows a good stop bit is detected with no idle gap.
// - Reset mid-frame: the frame is aborted immediately, with no strobe on release.
//   The receiver resyncs on the next falling edge.
//
// TESTING
// 1 PAR_EN=0, OS=8, frame 0xA5 -> P_DATA=8'hA5, DATA_VALID 1 cycle at cycle 83, Busy low after.
// 2 PAR_EN=1, PAR_TYP=0, 0x3C with parity=0 -> DATA_VALID, P_DATA=8'h3C.
//   Same frame with parity=1 -> PAR_ERR only, P_DATA stays 8'h3C.
// 3 RX_IN low for 2 cycles, then high -> back to IDLE, no strobes.
//   Busy pulses for at most OS cycles.
// 4 Stop bit driven 0, line held low 40 cycles -> one STP_ERR, no new frame until line goes high.
// 5 Odd parity, 0x00 then 0xFF back-to-back with no gap -> two DATA_VALIDs with 8'h00 and 8'hFF.
// 6 reset asserted mid-DATA of 0x5A -> outputs 0 at once.
//   Next frame 0x81 -> P_DATA=8'h81.
//   Loop back from the TX stage: 256 random bytes -> all matched.

Source files
------------

// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: synchronizes the serial line, majority-votes three
// mid-bit samples per bit and rebuilds START/DATA/PARITY/STOP frames.
module uart_rx_deserializer #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR,
  output logic                  Busy
);

  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CW-1:0] SAMP_LO  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] SAMP_MID = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] SAMP_HI  = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                  state_q;
  logic [CW-1:0]           edgeCnt_q;
  logic [BW-1:0]           bitCnt_q;
  logic [2:0]              samp_q;
  logic [2:0]              samp_d;
  logic [DATA_WIDTH-1:0]   rxShift_q;
  logic                    parEn_q;
  logic                    parTyp_q;
  logic                    parErrPend_q;
  logic                    armed_q;
  logic                    rxMeta_q;
  logic                    rxS_q;
  logic                    bitVal;
  logic                    bitEnd;

  // Two-flop synchronizer, preset to the idle-high line level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxMeta_q <= 1'b1;
      rxS_q    <= 1'b1;
    end else begin
      rxMeta_q <= RX_IN;
      rxS_q    <= rxMeta_q;
    end
  end

  // The last vote sample may land on the resolve edge for small OVERSAMPLE,
  // so the vote is taken over the sample set as updated by this edge.
  always_comb begin
    samp_d = samp_q;
    if (edgeCnt_q == SAMP_LO)  samp_d[0] = rxS_q;
    if (edgeCnt_q == SAMP_MID) samp_d[1] = rxS_q;
    if (edgeCnt_q == SAMP_HI)  samp_d[2] = rxS_q;
    bitVal = (samp_d[0] & samp_d[1]) | (samp_d[0] & samp_d[2]) | (samp_d[1] & samp_d[2]);
    bitEnd = (edgeCnt_q == CNT_LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      edgeCnt_q    <= '0;
      bitCnt_q     <= '0;
      samp_q       <= '1;
      rxShift_q    <= '0;
      parEn_q      <= 1'b0;
      parTyp_q     <= 1'b0;
      parErrPend_q <= 1'b0;
      armed_q      <= 1'b1;
      P_DATA       <= '0;
      DATA_VALID   <= 1'b0;
      PAR_ERR      <= 1'b0;
      STP_ERR      <= 1'b0;
      Busy         <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
      samp_q     <= samp_d;

      if (state_q == IDLE || bitEnd) begin
        edgeCnt_q <= '0;
      end else begin
        edgeCnt_q <= edgeCnt_q + CW'(1);
      end

      case (state_q)
        IDLE: begin
          if (rxS_q) begin
            armed_q <= 1'b1;
          end else if (armed_q) begin
            state_q      <= START;
            Busy         <= 1'b1;
            parEn_q      <= PAR_EN;
            parTyp_q     <= PAR_TYP;
            parErrPend_q <= 1'b0;
            bitCnt_q     <= '0;
          end
        end

        START: begin
          if (bitEnd) begin
            if (bitVal) begin
              state_q <= IDLE;
              Busy    <= 1'b0;
            end else begin
              state_q <= DATA;
            end
          end
        end

        DATA: begin
          if (bitEnd) begin
            rxShift_q <= {bitVal, rxShift_q[DATA_WIDTH-1:1]};
            if (bitCnt_q == BIT_LAST) begin
              bitCnt_q <= '0;
              state_q  <= parEn_q ? PARITY : STOP;
            end else begin
              bitCnt_q <= bitCnt_q + BW'(1);
            end
          end
        end

        PARITY: begin
          if (bitEnd) begin
            if (bitVal != (^rxShift_q ^ parTyp_q)) parErrPend_q <= 1'b1;
            state_q <= STOP;
          end
        end

        STOP: begin
          if (bitEnd) begin
            if (!bitVal) begin
              STP_ERR <= 1'b1;
              armed_q <= 1'b0;
              state_q <= IDLE;
              Busy    <= 1'b0;
            end else begin
              if (parErrPend_q) begin
                PAR_ERR <= 1'b1;
              end else begin
                P_DATA     <= rxShift_q;
                DATA_VALID <= 1'b1;
              end
              // A start bit already on the line right after a good stop bit
              // is taken here so back-to-back frames keep their bit alignment.
              if (!rxS_q && armed_q) begin
                state_q      <= START;
                parEn_q      <= PAR_EN;
                parTyp_q     <= PAR_TYP;
                parErrPend_q <= 1'b0;
                bitCnt_q     <= '0;
              end else begin
                state_q <= IDLE;
                Busy    <= 1'b0;
              end
            end
          end
        end

        default: begin
          state_q <= IDLE;
          Busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: serializes frames onto RX_IN and
// compares strobes and payload against hand-computed values.
module tb_uart_rx_deserializer;

  localparam int OS = 8;

  logic       clk;
  logic       reset;
  logic       RX_IN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_ERR;
  logic       STP_ERR;
  logic       Busy;

  int errors = 0;
  int checks = 0;
  int dvCnt = 0;
  int peCnt = 0;
  int seCnt = 0;
  int dv0, pe0, se0;
  logic [7:0] lastData = 8'h00;
  logic [7:0] dvLog[$];

  uart_rx_deserializer #(.DATA_WIDTH(8), .OVERSAMPLE(OS)) dut (
    .clk(clk),
    .reset(reset),
    .RX_IN(RX_IN),
    .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP),
    .P_DATA(P_DATA),
    .DATA_VALID(DATA_VALID),
    .PAR_ERR(PAR_ERR),
    .STP_ERR(STP_ERR),
    .Busy(Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (DATA_VALID) begin
      dvCnt++;
      lastData = P_DATA;
      dvLog.push_back(P_DATA);
    end
    if (PAR_ERR) peCnt++;
    if (STP_ERR) seCnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sendBit(input logic b);
    RX_IN = b;
    waitCycles(OS);
  endtask

  // Drives one frame starting at a negedge; flipPar inverts the parity bit.
  task automatic applyStimulus(input logic [7:0] data, input logic parEn, input logic parTyp,
                               input logic flipPar, input logic stopBit);
    PAR_EN  = parEn;
    PAR_TYP = parTyp;
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(data[i]);
    if (parEn) sendBit(^data ^ parTyp ^ flipPar);
    sendBit(stopBit);
  endtask

  task automatic snapshot();
    dv0 = dvCnt;
    pe0 = peCnt;
    se0 = seCnt;
  endtask

  initial begin
    int busyCycles;
    int logBase;
    logic [7:0] rnd;
    logic pe, pt;

    reset = 1'b0;
    RX_IN = 1'b1;
    PAR_EN = 1'b0;
    PAR_TYP = 1'b0;
    waitCycles(3);
    checkOutput("rst_pdata", 32'(P_DATA), 32'h00);
    checkOutput("rst_dv", 32'(DATA_VALID), 32'd0);
    checkOutput("rst_perr", 32'(PAR_ERR), 32'd0);
    checkOutput("rst_serr", 32'(STP_ERR), 32'd0);
    checkOutput("rst_busy", 32'(Busy), 32'd0);
    reset = 1'b1;
    waitCycles(4);

    // Frame 0xA5 without parity: strobe rises on the 83rd edge counted from the
    // edge that first samples the start bit.
    snapshot();
    fork
      applyStimulus(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
      begin
        repeat (82) @(posedge clk);
        #1;
        checkOutput("t1_dv_e82", 32'(DATA_VALID), 32'd0);
        checkOutput("t1_busy_e82", 32'(Busy), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("t1_dv_e83", 32'(DATA_VALID), 32'd1);
        checkOutput("t1_pdata", 32'(P_DATA), 32'hA5);
        @(posedge clk);
        #1;
        checkOutput("t1_dv_e84", 32'(DATA_VALID), 32'd0);
        checkOutput("t1_busy_after", 32'(Busy), 32'd0);
      end
    join
    @(negedge clk);
    RX_IN = 1'b1;
    waitCycles(4);
    checkOutput("t1_dv_count", 32'(dvCnt - dv0), 32'd1);

    // Even parity, 0x3C: good parity, then wrong parity on the same and another byte.
    snapshot();
    applyStimulus(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1);
    waitCycles(4);
    checkOutput("t2_dv_count", 32'(dvCnt - dv0), 32'd1);
    checkOutput("t2_pdata", 32'(lastData), 32'h3C);
    checkOutput("t2_pe_none", 32'(peCnt - pe0), 32'd0);
    snapshot();
    applyStimulus(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1);
    waitCycles(4);
    applyStimulus(8'h77, 1'b1, 1'b0, 1'b1, 1'b1);
    waitCycles(4);
    checkOutput("t2_pe_count", 32'(peCnt - pe0), 32'd2);
    checkOutput("t2_pe_no_dv", 32'(dvCnt - dv0), 32'd0);
    checkOutput("t2_pe_se_none", 32'(seCnt - se0), 32'd0);
    checkOutput("t2_pe_hold", 32'(P_DATA), 32'h3C);

    // Two-cycle glitch on an idle line.
    snapshot();
    busyCycles = 0;
    RX_IN = 1'b0;
    waitCycles(2);
    RX_IN = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (Busy) busyCycles++;
    end
    checkOutput("t3_busy_pulse", 32'(busyCycles >= 1 && busyCycles <= OS), 32'd1);
    checkOutput("t3_no_strobe", 32'((dvCnt - dv0) + (peCnt - pe0) + (seCnt - se0)), 32'd0);

    // Stop bit low, then line held low: one STP_ERR and no retrigger.
    snapshot();
    applyStimulus(8'h96, 1'b0, 1'b0, 1'b0, 1'b0);
    waitCycles(40);
    checkOutput("t4_se_count", 32'(seCnt - se0), 32'd1);
    checkOutput("t4_no_dv_pe", 32'((dvCnt - dv0) + (peCnt - pe0)), 32'd0);
    checkOutput("t4_idle_low", 32'(Busy), 32'd0);
    checkOutput("t4_pdata_hold", 32'(P_DATA), 32'h3C);
    RX_IN = 1'b1;
    waitCycles(4);
    snapshot();
    applyStimulus(8'h42, 1'b0, 1'b0, 1'b0, 1'b1);
    waitCycles(4);
    checkOutput("t4_recover_dv", 32'(dvCnt - dv0), 32'd1);
    checkOutput("t4_recover_data", 32'(lastData), 32'h42);

    // Odd parity, back-to-back 0x00 and 0xFF with no idle gap.
    snapshot();
    logBase = dvLog.size();
    applyStimulus(8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(8'hFF, 1'b1, 1'b1, 1'b0, 1'b1);
    RX_IN = 1'b1;
    waitCycles(4);
    checkOutput("t5_dv_count", 32'(dvCnt - dv0), 32'd2);
    checkOutput("t5_pe_none", 32'(peCnt - pe0), 32'd0);
    if (dvLog.size() >= logBase + 2) begin
      checkOutput("t5_first", 32'(dvLog[logBase]), 32'h00);
      checkOutput("t5_second", 32'(dvLog[logBase + 1]), 32'hFF);
    end else begin
      checkOutput("t5_log_len", 32'(dvLog.size() - logBase), 32'd2);
    end

    // Parity settings are latched at the start bit.
    snapshot();
    fork
      applyStimulus(8'h5B, 1'b0, 1'b0, 1'b0, 1'b1);
      begin
        waitCycles(20);
        PAR_EN = 1'b1;
        PAR_TYP = 1'b1;
      end
    join
    RX_IN = 1'b1;
    waitCycles(4);
    checkOutput("t5_latch_dv", 32'(dvCnt - dv0), 32'd1);
    checkOutput("t5_latch_data", 32'(lastData), 32'h5B);

    // Reset in the middle of the data bits of 0x5A.
    snapshot();
    fork
      applyStimulus(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
      begin
        waitCycles(40);
        checkOutput("t6_busy_pre", 32'(Busy), 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("t6_rst_pdata", 32'(P_DATA), 32'h00);
        checkOutput("t6_rst_busy", 32'(Busy), 32'd0);
      end
    join
    RX_IN = 1'b1;
    waitCycles(2);
    reset = 1'b1;
    waitCycles(4);
    checkOutput("t6_no_strobe", 32'((dvCnt - dv0) + (peCnt - pe0) + (seCnt - se0)), 32'd0);
    snapshot();
    applyStimulus(8'h81, 1'b0, 1'b0, 1'b0, 1'b1);
    waitCycles(4);
    checkOutput("t6_next_dv", 32'(dvCnt - dv0), 32'd1);
    checkOutput("t6_next_data", 32'(P_DATA), 32'h81);

    // Loopback of 256 random bytes with random parity settings.
    for (int n = 0; n < 256; n++) begin
      rnd = 8'($urandom);
      pe = 1'($urandom_range(0, 1));
      pt = 1'($urandom_range(0, 1));
      snapshot();
      applyStimulus(rnd, pe, pt, 1'b0, 1'b1);
      waitCycles(4);
      checkOutput("loop_dv", 32'(dvCnt - dv0), 32'd1);
      checkOutput("loop_data", 32'(lastData), 32'(rnd));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
